// File: rtl/wvb_arb_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter, readout engine and register map.
package wvb_arb_pkg;

    localparam int L_WVB_N_CHAN = 24;
    localparam int L_WVB_IDX_W  = 5;
    localparam int L_WVB_TMO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic state_is_busy(arb_state_e st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/wvb_rr_pick.sv
// Combinational round-robin priority encoder: first requester above last_idx, wrapping at N_CHAN.
module wvb_rr_pick #(
    parameter int N_CHAN      = 24,
    parameter int P_IDX_WIDTH = 5
) (
    input  logic [N_CHAN-1:0]      req,
    input  logic [P_IDX_WIDTH-1:0] last_idx,
    output logic [P_IDX_WIDTH-1:0] sel_idx,
    output logic                   sel_valid
);

    logic [31:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int k = N_CHAN; k >= 1; k--) begin
            cand = 32'(last_idx) + 32'(k);
            if (cand >= 32'(N_CHAN)) cand = cand - 32'(N_CHAN);
            if (cand >= 32'(N_CHAN)) cand = cand - 32'(N_CHAN);
            for (int j = 0; j < N_CHAN; j++) begin
                if (req[j] && (cand == 32'(j))) begin
                    sel_idx   = P_IDX_WIDTH'(j);
                    sel_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin arbiter sharing the waveform readout engine across per-channel buffers,
// holding each grant until rd_done or a read timeout.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no grant; pick next requester when enabled
//   ST_GRANT   | one channel owns the reader; timeout counter running
//   ST_RELEASE | one dead cycle so the released channel's FIFO flags settle
module wvb_rd_arbiter
    import wvb_arb_pkg::*;
#(
    parameter int N_CHAN      = L_WVB_N_CHAN,
    parameter int P_IDX_WIDTH = L_WVB_IDX_W,
    parameter int P_TMO_WIDTH = L_WVB_TMO_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_CHAN-1:0]      chan_mask,
    input  logic [N_CHAN-1:0]      hdr_empty,
    input  logic [P_TMO_WIDTH-1:0] tmo_limit,
    output logic [N_CHAN-1:0]      rd_grant,
    output logic [P_IDX_WIDTH-1:0] rd_chan,
    output logic                   rd_valid,
    input  logic                   rd_done,
    output logic                   rd_abort,
    output logic                   tmo_err,
    output logic                   busy
);

    arb_state_e             state_q, state_d;
    logic [P_TMO_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_IDX_WIDTH-1:0] last_idx_q, last_idx_d;
    logic [P_IDX_WIDTH-1:0] chan_q, chan_d;
    logic [N_CHAN-1:0]      grant_q, grant_d;
    logic                   abort_q, abort_d;
    logic                   tmo_err_q, tmo_err_d;

    logic [N_CHAN-1:0]      req;
    logic [P_IDX_WIDTH-1:0] sel_idx;
    logic                   sel_valid;
    logic                   tmo_hit;

    assign req     = ~hdr_empty & chan_mask;
    assign tmo_hit = (tmo_limit != '0) && (cnt_q == tmo_limit - P_TMO_WIDTH'(1));

    wvb_rr_pick #(
        .N_CHAN      (N_CHAN),
        .P_IDX_WIDTH (P_IDX_WIDTH)
    ) u_pick (
        .req       (req),
        .last_idx  (last_idx_q),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_idx_q <= P_IDX_WIDTH'(N_CHAN - 1);
            chan_q     <= '0;
            grant_q    <= '0;
            abort_q    <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            chan_q     <= chan_d;
            grant_q    <= grant_d;
            abort_q    <= abort_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        chan_d     = chan_q;
        grant_d    = grant_q;
        abort_d    = 1'b0;
        tmo_err_d  = tmo_err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en && sel_valid) begin
                    grant_d    = {{(N_CHAN-1){1'b0}}, 1'b1} << sel_idx;
                    chan_d     = sel_idx;
                    last_idx_d = sel_idx;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + P_TMO_WIDTH'(1);
                // rd_done takes precedence over a timeout landing on the same cycle.
                if (rd_done) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (tmo_hit) begin
                    grant_d   = '0;
                    abort_d   = 1'b1;
                    tmo_err_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_grant = grant_q;
    assign rd_chan  = chan_q;
    assign rd_valid = (state_q == ST_GRANT);
    assign rd_abort = abort_q;
    assign tmo_err  = tmo_err_q;
    assign busy     = state_is_busy(state_q);

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed and randomized bench for wvb_rd_arbiter against an event-level reference model.
module tb_wvb_rd_arbiter;

    localparam int N  = 24;
    localparam int IW = 5;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  chan_mask = '1;
    logic [N-1:0]  hdr_empty = '1;
    logic [TW-1:0] tmo_limit = '0;
    logic [N-1:0]  rd_grant;
    logic [IW-1:0] rd_chan;
    logic          rd_valid;
    logic          rd_done = 1'b0;
    logic          rd_abort;
    logic          tmo_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: owner channel (-1 = none), cycles held, release gap, last winner.
    int m_chan, m_age, m_last;
    bit m_rel, m_abort, m_err;

    always #5 clk = ~clk;

    wvb_rd_arbiter #(.N_CHAN(N), .P_IDX_WIDTH(IW), .P_TMO_WIDTH(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .chan_mask (chan_mask),
        .hdr_empty (hdr_empty),
        .tmo_limit (tmo_limit),
        .rd_grant  (rd_grant),
        .rd_chan   (rd_chan),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .rd_abort  (rd_abort),
        .tmo_err   (tmo_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_chan  = -1;
        m_age   = 0;
        m_last  = N - 1;
        m_rel   = 0;
        m_abort = 0;
        m_err   = 0;
    endtask

    task automatic check_all();
        logic [31:0] eg;
        eg = (m_chan >= 0) ? (32'd1 << m_chan) : 32'd0;
        chk("rd_grant", 32'(rd_grant), eg);
        chk("rd_valid", 32'(rd_valid), 32'(m_chan >= 0));
        if (m_chan >= 0) chk("rd_chan", 32'(rd_chan), 32'(m_chan));
        chk("rd_abort", 32'(rd_abort), 32'(m_abort));
        chk("tmo_err", 32'(tmo_err), 32'(m_err));
        chk("busy", 32'(busy), 32'((m_chan >= 0) || m_rel));
    endtask

    // Advance one clock: predict from the inputs presented now, then compare after the edge.
    task automatic step();
        bit nab;
        nab = 0;
        if (m_rel) begin
            m_rel = 0;
        end else if (m_chan >= 0) begin
            if (rd_done) begin
                m_chan = -1;
                m_rel  = 1;
            end else if (tmo_limit != 0 && (m_age + 1) == int'(tmo_limit)) begin
                m_chan = -1;
                m_rel  = 1;
                nab    = 1;
                m_err  = 1;
            end else begin
                m_age++;
            end
        end else if (en) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!hdr_empty[c] && chan_mask[c]) begin
                    m_chan = c;
                    m_last = c;
                    m_age  = 0;
                    break;
                end
            end
        end
        m_abort = nab;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !rd_valid; i++) step();
        chk("grant_wait", 32'(rd_valid), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_grant", 32'(rd_grant), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_chan", 32'(rd_chan), 32'd0);
        chk("rst_abort", 32'(rd_abort), 32'd0);
        chk("rst_tmo_err", 32'(tmo_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int order[$];
        int n;
        int exp_order[6];
        exp_order = '{0, 3, 23, 0, 3, 23};
        model_reset();
        en = 1'b1;
        do_reset();

        // Single channel
        hdr_empty = '1;
        hdr_empty[5] = 1'b0;
        step();
        chk("single_grant", 32'(rd_grant), 32'd1 << 5);
        chk("single_chan", 32'(rd_chan), 32'd5);
        steps(2);
        pulse_done();
        chk("single_valid_drop", 32'(rd_valid), 32'd0);
        chk("single_busy_rel", 32'(busy), 32'd1);
        step();
        chk("single_busy_fall", 32'(busy), 32'd0);
        hdr_empty = '1;
        steps(3);

        // Fairness among 0, 3, 23
        do_reset();
        hdr_empty = '1;
        hdr_empty[0] = 1'b0;
        hdr_empty[3] = 1'b0;
        hdr_empty[23] = 1'b0;
        for (int e = 0; e < 6; e++) begin
            wait_valid();
            order.push_back(int'(rd_chan));
            steps(4);
            pulse_done();
        end
        for (int e = 0; e < 6; e++) chk("fair_order", 32'(order[e]), 32'(exp_order[e]));
        hdr_empty = '1;
        steps(3);

        // Tie: rd_done on the expiry cycle
        do_reset();
        tmo_limit = 16'd4;
        hdr_empty[2] = 1'b0;
        wait_valid();
        steps(3);
        pulse_done();
        chk("tie_abort", 32'(rd_abort), 32'd0);
        chk("tie_tmo_err", 32'(tmo_err), 32'd0);
        hdr_empty = '1;
        steps(3);

        // Timeout
        do_reset();
        tmo_limit = 16'd10;
        hdr_empty[2] = 1'b0;
        hdr_empty[9] = 1'b0;
        wait_valid();
        chk("tmo_first_chan", 32'(rd_chan), 32'd2);
        n = 0;
        for (int i = 0; i < 20 && !rd_abort; i++) begin
            step();
            n++;
        end
        chk("tmo_abort_delay", 32'(n), 32'd10);
        chk("tmo_err_set", 32'(tmo_err), 32'd1);
        steps(2);
        chk("tmo_next_valid", 32'(rd_valid), 32'd1);
        chk("tmo_next_chan", 32'(rd_chan), 32'd9);
        pulse_done();
        steps(3);
        chk("tmo_err_sticky", 32'(tmo_err), 32'd1);
        hdr_empty = '1;
        tmo_limit = '0;
        steps(3);

        // Mask change during grant, then enable low
        do_reset();
        hdr_empty[7] = 1'b0;
        hdr_empty[8] = 1'b0;
        wait_valid();
        chk("mask_first_chan", 32'(rd_chan), 32'd7);
        chan_mask[7] = 1'b0;
        steps(5);
        chk("mask_held", 32'(rd_grant), 32'd1 << 7);
        pulse_done();
        for (int i = 0; i < 30; i++) begin
            if (rd_valid && (i % 5) == 0) pulse_done();
            else step();
            chk("mask_never7", 32'(rd_grant[7]), 32'd0);
        end
        chan_mask = '1;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid) pulse_done();
            else step();
        end
        chk("en_off_valid", 32'(rd_valid), 32'd0);
        en = 1'b1;

        // Async reset mid-grant
        do_reset();
        hdr_empty = '1;
        hdr_empty[5] = 1'b0;
        wait_valid();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_grant", 32'(rd_grant), 32'd0);
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        hdr_empty = '1;
        hdr_empty[0] = 1'b0;
        hdr_empty[1] = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("async_restart_chan", 32'(rd_chan), 32'd0);
        chk("async_restart_valid", 32'(rd_valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            hdr_empty = N'($urandom);
            chan_mask = N'($urandom) | N'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            rd_done   = ($urandom_range(0, 3) == 0);
            if (($urandom_range(0, 31)) == 0) tmo_limit = TW'($urandom_range(0, 8));
            step();
        end
        rd_done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wvb_rd_arbiter.md
Name: wvb_rd_arbiter

Overview:
- Round-robin arbiter that shares the single waveform-buffer readout engine among N_CHAN per-channel waveform buffers.
- A channel requests service while its header FIFO is non-empty and unmasked.
- The arbiter grants one channel at a time, holds the grant until the reader reports completion (which also drives that channel's wvb_rddone), and recovers from hung reads with a timeout.
- Sits between the per-channel wvb_overflow_ctrl/header FIFOs and the shared readout/DMA engine.

Parameters:
- N_CHAN, 24, number of waveform-buffer channels (2..32).
- P_IDX_WIDTH, 5, width of the channel index; must satisfy 2**P_IDX_WIDTH >= N_CHAN.
- P_TMO_WIDTH, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  arbitration enable; low = no new grants (current grant completes normally).
- chan_mask  in  N_CHAN  1 = channel eligible.
- hdr_empty  in  N_CHAN  per-channel header FIFO empty flags.
- tmo_limit  in  P_TMO_WIDTH  cycles allowed per read; 0 = timeout disabled.
- rd_grant  out  N_CHAN  one-hot grant (all-zero when idle).
- rd_chan  out  P_IDX_WIDTH  index of the granted channel; valid while rd_valid.
- rd_valid  out  1  a grant is active.
- rd_done  in  1  single-cycle pulse from the reader: event fully read.
- rd_abort  out  1  single-cycle pulse: grant revoked by timeout.
- tmo_err  out  1  sticky timeout flag; cleared only by reset.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - rd_grant=0, rd_chan=0, rd_valid=0, rd_abort=0, tmo_err=0, busy=0.
  - Round-robin pointer last_idx=N_CHAN-1, so channel 0 has first priority.
  - State=IDLE, timeout counter=0.
- Request vector: req = ~hdr_empty & chan_mask, sampled combinationally each cycle.
- Selection: the first set bit of req searching upward from last_idx+1, wrapping modulo N_CHAN (index N_CHAN-1 wraps to 0). Bits at or above N_CHAN do not exist.
- FSM:
  - IDLE: if en && |req, register the selected channel into rd_grant, rd_chan and last_idx, set rd_valid=1, and go to GRANT. The grant is visible the cycle after the request is seen (1-cycle latency).
  - GRANT: the timeout counter increments each cycle.
    - If rd_done: drop rd_grant/rd_valid on the next edge and go to RELEASE.
    - Else if tmo_limit!=0 and counter==tmo_limit-1: drop the grant, pulse rd_abort for 1 cycle, set tmo_err, and go to RELEASE.
  - RELEASE: exactly 1 cycle, with no grant. This lets hdr_empty/last_rd_addr in the released channel update after its rddone. Counter clears; go to IDLE.
- Throughput: back-to-back events occupy rd_done → RELEASE → IDLE → grant, so the minimum spacing is 3 cycles between a rd_done and the next rd_valid.
- Simultaneous rd_done and timeout expiry in the same cycle: rd_done wins, with no abort and no tmo_err.
- rd_done while in IDLE or RELEASE: ignored.
- Changing chan_mask or en during GRANT has no effect on the current grant. A masked channel is not re-granted afterwards.
- If the granted channel's hdr_empty rises during GRANT, the grant is held anyway; only rd_done or timeout ends it.
- rd_grant is always one-hot or zero, and rd_grant[rd_chan]==rd_valid.
- Reset mid-GRANT drops all outputs immediately (asynchronously). The next arbitration restarts from channel 0.

Decomposition:
- Shared package wvb_arb_pkg:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2.
  - L_WVB_N_CHAN=24 and its index width, reused by the readout engine and the register map.
- One sub-module, wvb_rr_pick: combinational round-robin priority encoder.
  - Inputs: req[N_CHAN], last_idx.
  - Outputs: sel_idx, sel_valid.
  - Used once by wvb_rd_arbiter; tested standalone with exhaustive small-N vectors.

Test Plan:
- Single channel: hdr_empty[5]=0 only, en=1 → rd_grant=1<<5 and rd_chan=5 one cycle later. rd_done pulse → rd_valid=0 next cycle, busy falls 2 cycles after rd_done.
- Fairness: channels 0, 3 and 23 permanently requesting, rd_done 4 cycles after each grant → grant order 0, 3, 23, 0, 3, 23…; no channel granted twice before the others.
- Timeout: tmo_limit=10, channel 2 granted, no rd_done → rd_abort pulses with the grant dropping 10 cycles after the grant; tmo_err=1 and stays set. The next requester is granted 2 cycles later.
- Tie: rd_done asserted on the exact expiry cycle (tmo_limit=4) → no rd_abort, tmo_err stays 0.
- Masking/enable: chan_mask[7] cleared during channel 7's grant → grant held until rd_done, channel 7 never re-granted. en=0 with requests pending → no rd_valid.
- Async reset: assert rst_n low mid-GRANT between clock edges → rd_grant=0 and rd_valid=0 immediately. After release, a 0 and 1 request pair is granted to channel 0 first.
